// File: rtl/tmds_video_encoder.sv
// Three-channel DVI/HDMI TMDS 8b/10b encoder (blue=ch0, green=ch1, red=ch2), two-stage pipeline.
// Define VIDEO_GUARD_BAND_EN to insert the HDMI leading video guard band (latency grows from 2 to 4).
module tmds_video_encoder (
  input  logic       clk_hdmi_in,
  input  logic       rst_in,
  input  logic       vsync_in,
  input  logic       hsync_in,
  input  logic       active_draw_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [9:0] tmds_red_out,
  output logic [9:0] tmds_green_out,
  output logic [9:0] tmds_blue_out
);
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  logic [7:0] pix [3];
  logic [9:0] sym_out [3];
  logic       s1_act_reg;
  logic [1:0] s1_ctrl_reg;

  assign pix[0] = blue_in;
  assign pix[1] = green_in;
  assign pix[2] = red_in;

  always_ff @(posedge clk_hdmi_in) begin
    if (rst_in) begin
      s1_act_reg  <= 1'b0;
      s1_ctrl_reg <= 2'b00;
    end else begin
      s1_act_reg  <= active_draw_in;
      s1_ctrl_reg <= {vsync_in, hsync_in};
    end
  end

`ifdef VIDEO_GUARD_BAND_EN
  localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

  logic s2_act_reg;
  logic dly_act_reg;
  logic guard_sel;

  always_ff @(posedge clk_hdmi_in) begin
    if (rst_in) begin
      s2_act_reg  <= 1'b0;
      dly_act_reg <= 1'b0;
    end else begin
      s2_act_reg  <= s1_act_reg;
      dly_act_reg <= s2_act_reg;
    end
  end

  // Replace a control symbol when video follows within the next two symbols.
  assign guard_sel = !dly_act_reg && (s2_act_reg || s1_act_reg);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [3:0]        ones;
      logic              use_xnor;
      logic              acc;
      logic [7:0]        prefix;
      logic [8:0]        q_m_next;
      logic [8:0]        q_m_reg;
      logic [3:0]        n1;
      logic signed [4:0] diff;
      logic signed [4:0] two_q8;
      logic signed [4:0] cnt_reg;
      logic signed [4:0] cnt_next;
      logic [1:0]        ctrl;
      logic [9:0]        ctrl_sym;
      logic [9:0]        sym_next;
      logic [9:0]        sym_reg;

      // XNOR chain equals the XOR prefix with every odd bit inverted.
      always_comb begin
        ones     = 4'($countones(pix[gi]));
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !pix[gi][0]);
        acc      = 1'b0;
        prefix   = '0;
        for (int i = 0; i < 8; i++) begin
          acc       = acc ^ pix[gi][i];
          prefix[i] = acc;
        end
        q_m_next = {~use_xnor, use_xnor ? (prefix ^ 8'b1010_1010) : prefix};
      end

      always_ff @(posedge clk_hdmi_in) begin
        if (rst_in) q_m_reg <= '0;
        else        q_m_reg <= q_m_next;
      end

      always_comb begin
        ctrl = (gi == 0) ? s1_ctrl_reg : 2'b00;
        case (ctrl)
          2'b00:   ctrl_sym = CTRL_00;
          2'b01:   ctrl_sym = CTRL_01;
          2'b10:   ctrl_sym = CTRL_10;
          default: ctrl_sym = CTRL_11;
        endcase
        n1       = 4'($countones(q_m_reg[7:0]));
        diff     = $signed({n1, 1'b0} - 5'd8);
        two_q8   = $signed({3'b000, q_m_reg[8], 1'b0});
        sym_next = ctrl_sym;
        cnt_next = 5'sd0;
        if (s1_act_reg) begin
          if ((cnt_reg == 5'sd0) || (n1 == 4'd4)) begin
            sym_next = {~q_m_reg[8], q_m_reg[8], q_m_reg[8] ? q_m_reg[7:0] : ~q_m_reg[7:0]};
            cnt_next = q_m_reg[8] ? (cnt_reg + diff) : (cnt_reg - diff);
          end else if (((cnt_reg > 5'sd0) && (n1 > 4'd4)) || ((cnt_reg < 5'sd0) && (n1 < 4'd4))) begin
            sym_next = {1'b1, q_m_reg[8], ~q_m_reg[7:0]};
            cnt_next = cnt_reg + two_q8 - diff;
          end else begin
            sym_next = {1'b0, q_m_reg[8], q_m_reg[7:0]};
            cnt_next = cnt_reg + diff - (q_m_reg[8] ? 5'sd0 : 5'sd2);
          end
        end
      end

      always_ff @(posedge clk_hdmi_in) begin
        if (rst_in) begin
          sym_reg <= CTRL_00;
          cnt_reg <= 5'sd0;
        end else begin
          sym_reg <= sym_next;
          cnt_reg <= cnt_next;
        end
      end

`ifdef VIDEO_GUARD_BAND_EN
      localparam logic [9:0] GUARD = (gi == 1) ? GUARD_CH1 : GUARD_CH02;
      logic [9:0] dly_reg;
      logic [9:0] out_reg;

      always_ff @(posedge clk_hdmi_in) begin
        if (rst_in) begin
          dly_reg <= CTRL_00;
          out_reg <= CTRL_00;
        end else begin
          dly_reg <= sym_reg;
          out_reg <= guard_sel ? GUARD : dly_reg;
        end
      end

      assign sym_out[gi] = out_reg;
`else
      assign sym_out[gi] = sym_reg;
`endif
    end
  endgenerate

  assign tmds_blue_out  = sym_out[0];
  assign tmds_green_out = sym_out[1];
  assign tmds_red_out   = sym_out[2];
endmodule

// File: tb/tb_tmds_video_encoder.sv
// Directed bench for tmds_video_encoder; outputs are logged every cycle and checked against hand-derived symbols.
// Random-pixel run checks by TMDS decoding and running disparity of the emitted symbols.
`timescale 1ns/1ps
module tb_tmds_video_encoder;
  logic       clk = 1'b0;
  logic       rst_in, vsync_in, hsync_in, active_draw_in;
  logic [7:0] red_in, green_in, blue_in;
  logic [9:0] tmds_red_out, tmds_green_out, tmds_blue_out;

`ifdef VIDEO_GUARD_BAND_EN
  localparam int LAT = 4;
  localparam bit GB  = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit GB  = 1'b0;
`endif

  localparam logic [9:0] CTRL_00  = 10'b1101010100;
  localparam logic [9:0] CTRL_01  = 10'b0010101011;
  localparam logic [9:0] CTRL_11  = 10'b1010101011;
  localparam logic [9:0] GB_CH02  = 10'b1011001100;
  localparam logic [9:0] GB_CH1   = 10'b0100110011;
  localparam logic [9:0] SYM_A5   = 10'b0101100011;
  localparam logic [9:0] SYM_10   = 10'b0111110000;
  localparam logic [9:0] SYM_00_A = 10'b0100000000;

  int tests = 0;
  int fails = 0;
  int nstep = 0;
  logic [9:0] log_b [0:4095];
  logic [9:0] log_g [0:4095];
  logic [9:0] log_r [0:4095];

  tmds_video_encoder dut (
    .clk_hdmi_in(clk), .rst_in(rst_in), .vsync_in(vsync_in), .hsync_in(hsync_in),
    .active_draw_in(active_draw_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .tmds_red_out(tmds_red_out), .tmds_green_out(tmds_green_out), .tmds_blue_out(tmds_blue_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (nstep >= 4096) begin
      $display("FAIL log_overflow: step %0d beyond limit 4096", nstep);
      $fatal(1, "log overflow");
    end
    log_b[nstep] = tmds_blue_out;
    log_g[nstep] = tmds_green_out;
    log_r[nstep] = tmds_red_out;
    $display("[TB] cyc %0d rst=%b act=%b hs=%b vs=%b rgb=%h_%h_%h -> r=%b g=%b b=%b",
             nstep, rst_in, active_draw_in, hsync_in, vsync_in, red_in, green_in, blue_in,
             tmds_red_out, tmds_green_out, tmds_blue_out);
    nstep++;
  endtask

  task automatic drive(input logic a, input logic hs, input logic vs,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    active_draw_in = a; hsync_in = hs; vsync_in = vs;
    red_in = rr; green_in = gg; blue_in = bb;
    step();
  endtask

  task automatic ctrl_steps(input int n, input logic hs, input logic vs);
    for (int i = 0; i < n; i++) drive(1'b0, hs, vs, 8'h00, 8'h00, 8'h00);
  endtask

  function automatic logic [9:0] log_ch(input int c, input int idx);
    if (c == 0) return log_b[idx];
    if (c == 1) return log_g[idx];
    return log_r[idx];
  endfunction

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic test_reset();
    int base;
    logic [9:0] got;
    rst_in = 1'b1;
    ctrl_steps(2, 1'b0, 1'b0);
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5);
    rst_in = 1'b1;
    base = nstep;
    for (int i = 0; i < 3; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    rst_in = 1'b0;
    ctrl_steps(LAT, 1'b0, 1'b0);
    for (int k = 0; k < 3 + LAT; k++)
      for (int c = 0; c < 3; c++) begin
        got = log_ch(c, base + k);
        tests++;
        if (got !== CTRL_00) begin
          fails++;
          $display("FAIL reset_hold ch%0d cyc+%0d: got %b expected %b", c, k, got, CTRL_00);
        end
      end
  endtask

  task automatic test_control();
    int i0;
    logic [9:0] got;
    i0 = nstep;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    ctrl_steps(LAT, 1'b0, 1'b0);
    tests++;
    if (log_b[i0 + LAT - 2] !== CTRL_00) begin
      fails++;
      $display("FAIL ctrl_early ch0: got %b expected %b", log_b[i0 + LAT - 2], CTRL_00);
    end
    tests++;
    if (log_b[i0 + LAT - 1] !== CTRL_01) begin
      fails++;
      $display("FAIL ctrl_hsync ch0: got %b expected %b", log_b[i0 + LAT - 1], CTRL_01);
    end
    tests++;
    if (log_b[i0 + LAT] !== CTRL_11) begin
      fails++;
      $display("FAIL ctrl_both ch0: got %b expected %b", log_b[i0 + LAT], CTRL_11);
    end
    for (int c = 1; c < 3; c++) begin
      got = log_ch(c, i0 + LAT - 1);
      tests++;
      if (got !== CTRL_00) begin
        fails++;
        $display("FAIL ctrl_hsync ch%0d: got %b expected %b", c, got, CTRL_00);
      end
    end
  endtask

  task automatic test_dc_balance();
    int i0;
    logic [9:0] exp_b [4];
    logic [9:0] exp_g [4];
    exp_b = '{10'b0100000000, 10'b1111111111, 10'b0100000000, 10'b1111111111};
    exp_g = '{10'b1000000000, 10'b0011111111, 10'b0011111111, 10'b1000000000};
    i0 = nstep;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'hFF, 8'h00);
    ctrl_steps(LAT, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (log_b[i0 + i + LAT - 1] !== exp_b[i]) begin
        fails++;
        $display("FAIL dc_blue00 px%0d: got %b expected %b", i, log_b[i0 + i + LAT - 1], exp_b[i]);
      end
      tests++;
      if (log_g[i0 + i + LAT - 1] !== exp_g[i]) begin
        fails++;
        $display("FAIL dc_greenFF px%0d: got %b expected %b", i, log_g[i0 + i + LAT - 1], exp_g[i]);
      end
      tests++;
      if (log_r[i0 + i + LAT - 1] !== SYM_A5) begin
        fails++;
        $display("FAIL dc_redA5 px%0d: got %b expected %b", i, log_r[i0 + i + LAT - 1], SYM_A5);
      end
    end
  endtask

  task automatic test_random();
    int i0;
    int disp [3];
    logic [7:0] in_px [3][1000];
    logic [9:0] got;
    logic [7:0] dec;
    i0 = nstep;
    for (int i = 0; i < 1000; i++) begin
      for (int c = 0; c < 3; c++) in_px[c][i] = 8'($urandom_range(0, 255));
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            in_px[2][i], in_px[1][i], in_px[0][i]);
    end
    ctrl_steps(LAT, 1'b0, 1'b0);
    disp = '{0, 0, 0};
    for (int i = 0; i < 1000; i++)
      for (int c = 0; c < 3; c++) begin
        got = log_ch(c, i0 + i + LAT - 1);
        dec = tmds_decode(got);
        tests++;
        if (dec !== in_px[c][i]) begin
          fails++;
          $display("FAIL rnd_decode ch%0d px%0d: got %h (sym %b) expected %h", c, i, dec, got, in_px[c][i]);
        end
        disp[c] += 2 * $countones(got) - 10;
        tests++;
        if (disp[c] > 10 || disp[c] < -10) begin
          fails++;
          $display("FAIL rnd_disparity ch%0d px%0d: got %0d required within -10..10", c, i, disp[c]);
        end
      end
  endtask

  task automatic test_reset_midline();
    int r;
    int ip;
    logic [9:0] got;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5);
    rst_in = 1'b1;
    r = nstep;
    drive(1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'hA5);
    rst_in = 1'b0;
    ip = nstep;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    ctrl_steps(LAT, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      got = log_ch(c, r);
      tests++;
      if (got !== CTRL_00) begin
        fails++;
        $display("FAIL midline_rst ch%0d: got %b expected %b", c, got, CTRL_00);
      end
      got = log_ch(c, ip + LAT - 1);
      tests++;
      if (got !== SYM_00_A) begin
        fails++;
        $display("FAIL post_rst_cnt0 ch%0d: got %b expected %b", c, got, SYM_00_A);
      end
    end
    for (int k = r; k <= ip + LAT - 2; k++) begin
      tests++;
      if (log_g[k] === SYM_A5) begin
        fails++;
        $display("FAIL stale_video cyc%0d: got %b required not %b", k, log_g[k], SYM_A5);
      end
    end
  endtask

  task automatic test_guard_band();
    int n;
    logic [9:0] got;
    logic [9:0] want;
    ctrl_steps(10, 1'b1, 1'b0);
    n = nstep;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h10, 8'h10);
    ctrl_steps(LAT, 1'b0, 1'b0);
    for (int k = 0; k <= LAT - 2; k++)
      for (int c = 0; c < 3; c++) begin
        got = log_ch(c, n + k);
        if (GB && k >= LAT - 3) want = (c == 1) ? GB_CH1 : GB_CH02;
        else                    want = (c == 0) ? CTRL_01 : CTRL_00;
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL guard_lead ch%0d cyc N+%0d: got %b expected %b", c, k + 1, got, want);
        end
      end
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++) begin
        got = log_ch(c, n + i + LAT - 1);
        tests++;
        if (got !== SYM_10) begin
          fails++;
          $display("FAIL guard_video ch%0d px%0d: got %b expected %b", c, i, got, SYM_10);
        end
      end
  endtask

  task automatic test_short_gap();
    int i0;
    logic [9:0] got;
    logic [9:0] want;
    i0 = nstep;
    for (int i = 0; i < 7; i++) drive(i != 3, 1'b0, 1'b0, 8'h10, 8'h10, 8'h10);
    ctrl_steps(LAT, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      for (int c = 0; c < 3; c++) begin
        got = log_ch(c, i0 + i + LAT - 1);
        if (i != 3)  want = SYM_10;
        else if (GB) want = (c == 1) ? GB_CH1 : GB_CH02;
        else         want = CTRL_00;
        tests++;
        if (got !== want) begin
          fails++;
          $display("FAIL short_gap ch%0d slot%0d: got %b expected %b", c, i, got, want);
        end
      end
  endtask

  initial begin
    rst_in = 1'b1; active_draw_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00;
    test_reset();
    test_control();
    test_dc_balance();
    test_random();
    test_reset_midline();
    test_guard_band();
    test_short_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tmds_video_encoder.md
TMDS_VIDEO_ENCODER -- requirements
Module: tmds_video_encoder

Interface
REQ-001 SHALL expose: clk_hdmi_in  input  1  pixel clock; all logic on its rising edge.
REQ-002 SHALL expose: rst_in  input  1  reset; synchronous and active-high.
REQ-003 SHALL expose: vsync_in  input  1  vertical sync from the video controller.
REQ-004 SHALL expose: hsync_in  input  1  horizontal sync from the video controller.
REQ-005 SHALL expose: active_draw_in  input  1  high while the pixel is in the visible area.
REQ-006 SHALL expose: red_in, green_in, blue_in  input  8 each  pixel colour.
REQ-007 SHALL expose: tmds_red_out, tmds_green_out, tmds_blue_out  output  10 each  TMDS symbols for channels 2, 1 and 0.

Function
REQ-008 SHALL encode each channel per DVI 1.0 8b/10b, as a two-stage pipeline.
- Stage 1: count the ones in d; build 9-bit q_m, using XNOR if ones>4 or (ones==4 and d[0]==0), else XOR.
- Stage 2: form 10-bit symbol from q_m and the running disparity cnt.
REQ-009 SHALL keep one cnt per channel as a signed 5-bit value; arithmetic in 5-bit two's complement; |cnt| never exceeds 10.
REQ-010 When cnt==0 or ones(q_m[7:0])==4, SHALL output:
- q_out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
- cnt += q_m[8] ? (n1-n0) : (n0-n1).
REQ-011 Otherwise, if (cnt>0 and n1>n0) or (cnt<0 and n0>n1), SHALL output:
- q_out = {1, q_m[8], ~q_m[7:0]}.
- cnt += 2*q_m[8] + (n0-n1).
- Else q_out = {0, q_m[8], q_m[7:0]}; cnt += n1-n0 - 2*~q_m[8].
REQ-012 When active_draw is low, SHALL emit a control code from {c1,c0}:
- 00 -> 1101010100; 01 -> 0010101011; 10 -> 0101010100; 11 -> 1010101011.
- The control period forces cnt to 0.
REQ-013 Control bit mapping: channel 0 uses c0=hsync_in, c1=vsync_in; channels 1 and 2 use c1=c0=0.
REQ-014 When active_draw_in is high, SHALL ignore sync inputs for encoding (video wins on simultaneous events).
REQ-015 Latency (guard band compiled out): input sampled at cycle N appears on the outputs at cycle N+2; throughput is one symbol per clock, no stalls.
REQ-016 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-017 SHALL keep the three channels cycle-aligned with each other at all times.

Reset
REQ-018 While rst_in is high at a clock edge:
- All outputs become 1101010100 on the next cycle.
- All cnt become 0.
- All pipeline valid/active flags clear.
REQ-019 Reset asserted mid-line SHALL discard in-flight pixels; no stale video symbol appears after reset.
REQ-020 The first active pixel after reset releases SHALL be encoded with cnt=0.

Configuration
REQ-021 Macro VIDEO_GUARD_BAND_EN SHALL control the HDMI leading video guard band.
REQ-022 With VIDEO_GUARD_BAND_EN defined:
- Latency becomes 4 cycles.
- The two output symbols immediately preceding the first active symbol of each active run SHALL be guard band codes: ch0 1011001100, ch1 0100110011, ch2 1011001100.
- Guard band symbols leave cnt at 0.
REQ-023 Guard band SHALL only replace control-period symbols.
- If fewer than two control symbols precede an active run (including directly after reset), only those available are replaced.
- Video symbols are never overwritten.
REQ-024 Without VIDEO_GUARD_BAND_EN: latency 2, no guard band, and no extra delay registers are inferred.

Verification
REQ-025 Reset: hold rst_in 3 cycles with random inputs -> all outputs 1101010100 on the cycle after the first reset edge and while held.
REQ-026 Control: active low, hsync=1, vsync=0 -> ch0 0010101011, ch1/ch2 1101010100, exactly 2 cycles later; vsync=1, hsync=1 -> ch0 1010101011.
REQ-027 DC balance: active high, blue=0x00 from cnt=0 -> ch0 emits 0100000000, then 1111111111; cnt goes -8, then +2.
- Drive 1000 random pixels -> cnt stays within ±10 and a reference model matches bit-exactly.
REQ-028 Reset mid-line: assert rst_in during an active run of 0xA5 pixels -> next output is 1101010100; the first post-reset active pixel is encoded from cnt=0.
REQ-029 Guard band (macro defined): control for 10 cycles, then active_draw rises at cycle N with red=green=blue=0x10.
- Cycles N+2 and N+3 carry the guard band codes.
- Cycle N+4 carries the first video symbol.
- Rerun without the macro -> video at N+2, no guard band.
REQ-030 Short gap (macro defined): active low for exactly 1 cycle between runs -> that single symbol is guard band and no video symbol is replaced.
